// File: rtl/tb_mem_result_checker_if.sv
// -----------------------------------------------------------------------------
// tb_mem_result_checker_if
// Data-memory port between a CPU data interface and the bench memory model.
//   d_mem_addr   : byte address from the CPU
//   d_mem_wdata  : write data
//   d_mem_wen    : byte-lane write enables, bit i covers bits 8i+7:8i
//   d_mem_rdata  : combinational read data returned by the memory
// master = CPU side, slave = memory side.
// -----------------------------------------------------------------------------
interface tb_mem_result_checker_if;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic [31:0] d_mem_rdata;

  modport master (
    output d_mem_addr,
    output d_mem_wdata,
    output d_mem_wen,
    input  d_mem_rdata
  );

  modport slave (
    input  d_mem_addr,
    input  d_mem_wdata,
    input  d_mem_wen,
    output d_mem_rdata
  );
endinterface

// File: rtl/tb_mem_result_checker.sv
// -----------------------------------------------------------------------------
// tb_mem_result_checker
// Clocked data-memory model with byte-lane writes, completion-flag detection,
// a RUN-cycle watchdog and a post-run scanner that walks the result region.
// Ports:
//   clk, rst     : single clock, synchronous active-high reset
//   dmem         : data-memory port (slave side of tb_mem_result_checker_if)
//   finished     : checking complete, sticky until rst
//   pass         : no timeout and no inversions, valid when finished
//   timeout      : watchdog expired before the completion write
//   scan_busy    : high while the result region is being scanned
//   late_write   : sticky, a write arrived after RUN
//   oob_write    : sticky, a write addressed beyond the array
//   cycles_run   : RUN cycles elapsed, frozen when RUN is left
//   inv_count    : adjacent pairs with result[i] > result[i+1], saturating
//   res_sum      : sum of the result words modulo 2^32
// -----------------------------------------------------------------------------
module tb_mem_result_checker #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] DONE_ADDR   = 32'h400,
  parameter logic [31:0] DONE_VALUE  = 32'd1,
  parameter logic [31:0] RES_BASE    = 32'h300,
  parameter int          RES_COUNT   = 10,
  parameter int          MAX_CYCLES  = 15000,
  parameter int          CYC_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  tb_mem_result_checker_if.slave    dmem,
  output logic                      finished,
  output logic                      pass,
  output logic                      timeout,
  output logic                      scan_busy,
  output logic                      late_write,
  output logic                      oob_write,
  output logic [CYC_W-1:0]          cycles_run,
  output logic [15:0]               inv_count,
  output logic [31:0]               res_sum
);

  localparam int                AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]       MEM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam int                IDX_W     = (RES_COUNT > 1) ? $clog2(RES_COUNT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RES_COUNT - 1);
  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Merge the enabled byte lanes of wdata into the old word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // The array has no reset: contents survive rst so results stay inspectable.
  logic [31:0]      mem_r [0:DEPTH_WORDS-1];

  state_t           state_r;
  logic [IDX_W-1:0] scan_idx_r;
  logic [31:0]      prev_r;
  logic             finished_r, pass_r, timeout_r, scan_busy_r;
  logic             late_write_r, oob_write_r;
  logic [CYC_W-1:0] cycles_run_r;
  logic [15:0]      inv_count_r;
  logic [31:0]      res_sum_r;

  logic             wr_any_s, wr_in_range_s, mem_we_s, done_evt_s;
  logic [AW-1:0]    rd_idx_s;
  logic [31:0]      scan_addr_s;
  logic             scan_in_range_s;
  logic [31:0]      scan_word_s;
  logic             inv_inc_s;
  logic [15:0]      inv_next_s;

  assign wr_any_s      = |dmem.d_mem_wen;
  assign wr_in_range_s = (dmem.d_mem_addr < MEM_BYTES);
  assign rd_idx_s      = dmem.d_mem_addr[AW+1:2];
  assign mem_we_s      = (state_r == ST_RUN) && wr_any_s && wr_in_range_s;
  assign done_evt_s    = (state_r == ST_RUN) && (dmem.d_mem_wen == 4'b1111) &&
                         (dmem.d_mem_addr == DONE_ADDR) && (dmem.d_mem_wdata == DONE_VALUE);

  // The scanner uses its own read port so the CPU port stays live in every state.
  assign scan_addr_s     = RES_BASE + (32'(scan_idx_r) << 2);
  assign scan_in_range_s = (scan_addr_s < MEM_BYTES);

  // CPU read port: zero latency, out-of-range addresses read as zero.
  always_comb begin
    dmem.d_mem_rdata = 32'h0;
    if (wr_in_range_s) begin
      dmem.d_mem_rdata = mem_r[rd_idx_s];
    end else begin
      dmem.d_mem_rdata = 32'h0;
    end
  end

  // Scanner read port and saturating inversion counter update.
  always_comb begin
    scan_word_s = 32'h0;
    if (scan_in_range_s) begin
      scan_word_s = mem_r[scan_addr_s[AW+1:2]];
    end else begin
      scan_word_s = 32'h0;
    end
    inv_inc_s  = (scan_idx_r != {IDX_W{1'b0}}) && (prev_r > scan_word_s) &&
                 (inv_count_r != 16'hFFFF);
    inv_next_s = inv_count_r + (inv_inc_s ? 16'd1 : 16'd0);
  end

  // Memory array: byte-lane writes accepted only in RUN and only in range.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[rd_idx_s] <= merge_lanes(mem_r[rd_idx_s], dmem.d_mem_wdata, dmem.d_mem_wen);
    end
  end

  // Control FSM: RUN with watchdog, SCAN of the result region, terminal FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_RUN;
      scan_idx_r   <= {IDX_W{1'b0}};
      prev_r       <= 32'h0;
      finished_r   <= 1'b0;
      pass_r       <= 1'b0;
      timeout_r    <= 1'b0;
      scan_busy_r  <= 1'b0;
      late_write_r <= 1'b0;
      oob_write_r  <= 1'b0;
      cycles_run_r <= {CYC_W{1'b0}};
      inv_count_r  <= 16'h0;
      res_sum_r    <= 32'h0;
    end else begin
      case (state_r)
        ST_RUN: begin
          // A done event on the last watchdog cycle wins over the timeout.
          if (done_evt_s) begin
            state_r     <= ST_SCAN;
            scan_busy_r <= 1'b1;
          end else if (cycles_run_r == LAST_CYC) begin
            state_r     <= ST_SCAN;
            scan_busy_r <= 1'b1;
            timeout_r   <= 1'b1;
          end else begin
            cycles_run_r <= cycles_run_r + {{(CYC_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SCAN: begin
          res_sum_r   <= res_sum_r + scan_word_s;
          inv_count_r <= inv_next_s;
          prev_r      <= scan_word_s;
          if (scan_idx_r == LAST_IDX) begin
            state_r     <= ST_FIN;
            scan_busy_r <= 1'b0;
            finished_r  <= 1'b1;
            pass_r      <= !timeout_r && (inv_next_s == 16'h0);
          end else begin
            scan_idx_r <= scan_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FIN: begin
          state_r <= ST_FIN;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
      if (wr_any_s && !wr_in_range_s) begin
        oob_write_r <= 1'b1;
      end
      if (wr_any_s && (state_r != ST_RUN)) begin
        late_write_r <= 1'b1;
      end
    end
  end

  assign finished   = finished_r;
  assign pass       = pass_r;
  assign timeout    = timeout_r;
  assign scan_busy  = scan_busy_r;
  assign late_write = late_write_r;
  assign oob_write  = oob_write_r;
  assign cycles_run = cycles_run_r;
  assign inv_count  = inv_count_r;
  assign res_sum    = res_sum_r;

endmodule

// File: tb/tb_tb_mem_result_checker.sv
// -----------------------------------------------------------------------------
// tb_tb_mem_result_checker
// Directed plus randomized bench for tb_mem_result_checker (MAX_CYCLES=50).
// A shadow memory tracks every committed write; expected scan results are
// computed from it with a plain loop over the result words.
// -----------------------------------------------------------------------------
module tb_tb_mem_result_checker;
  localparam int          MAXC = 50;
  localparam int          RC   = 10;
  localparam logic [31:0] RB   = 32'h300;
  localparam logic [31:0] DA   = 32'h400;

  logic        clk = 1'b0;
  logic        rst;
  logic        finished, pass, timeout, scan_busy, late_write, oob_write;
  logic [31:0] cycles_run;
  logic [15:0] inv_count;
  logic [31:0] res_sum;

  tb_mem_result_checker_if bus ();

  tb_mem_result_checker #(
    .DEPTH_WORDS(1024), .DONE_ADDR(32'h400), .DONE_VALUE(32'd1),
    .RES_BASE(32'h300), .RES_COUNT(RC), .MAX_CYCLES(MAXC), .CYC_W(32)
  ) dut (
    .clk(clk), .rst(rst), .dmem(bus),
    .finished(finished), .pass(pass), .timeout(timeout), .scan_busy(scan_busy),
    .late_write(late_write), .oob_write(oob_write), .cycles_run(cycles_run),
    .inv_count(inv_count), .res_sum(res_sum)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] model_mem [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.d_mem_wen = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Drive one write for one cycle; commit=1 means the memory should accept it.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] wen, input bit commit);
    bus.d_mem_addr  = addr;
    bus.d_mem_wdata = data;
    bus.d_mem_wen   = wen;
    if (commit && addr < 32'h1000) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) model_mem[addr >> 2][8*i +: 8] = data[8*i +: 8];
      end
    end
    tick();
    bus.d_mem_wen = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
    bus.d_mem_addr = addr;
    bus.d_mem_wen  = 4'h0;
    #1;
    chk(tag, bus.d_mem_rdata, exp_v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_finished"}, {31'd0, finished}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_scan_busy"}, {31'd0, scan_busy}, 32'd0);
    chk({tag, "_late"}, {31'd0, late_write}, 32'd0);
    chk({tag, "_oob"}, {31'd0, oob_write}, 32'd0);
    chk({tag, "_cycles"}, cycles_run, 32'd0);
    chk({tag, "_inv"}, {16'd0, inv_count}, 32'd0);
    chk({tag, "_sum"}, res_sum, 32'd0);
  endtask

  // Idle to the target cycle, optionally write the done flag, then follow the
  // scan window and compare the final report with the shadow-memory model.
  task automatic run_to_end(input bit do_done, input int done_at, input string tag);
    int          target;
    int          inv;
    logic [31:0] sum, w, prev;
    bit          exp_to;
    target = do_done ? done_at : MAXC - 1;
    while (cyc < target) tick();
    chk({tag, "_cycles_at_evt"}, cycles_run, 32'(target));
    chk({tag, "_busy_in_run"}, {31'd0, scan_busy}, 32'd0);
    if (do_done) wr(DA, 32'd1, 4'hF, 1'b1);
    else tick();
    exp_to = !do_done;
    inv = 0; sum = 32'd0; prev = 32'd0;
    for (int i = 0; i < RC; i++) begin
      w = model_mem[(RB >> 2) + i];
      sum = sum + w;
      if (i > 0 && prev > w) inv++;
      prev = w;
    end
    for (int k = 0; k < RC; k++) begin
      chk({tag, "_scan_busy"}, {31'd0, scan_busy}, 32'd1);
      chk({tag, "_not_finished"}, {31'd0, finished}, 32'd0);
      tick();
    end
    chk({tag, "_finished"}, {31'd0, finished}, 32'd1);
    chk({tag, "_busy_off"}, {31'd0, scan_busy}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    chk({tag, "_pass"}, {31'd0, pass}, (!exp_to && inv == 0) ? 32'd1 : 32'd0);
    chk({tag, "_inv"}, {16'd0, inv_count}, 32'(inv));
    chk({tag, "_sum"}, res_sum, sum);
    chk({tag, "_cycles_frozen"}, cycles_run, 32'(target));
  endtask

  initial begin
    int          unsorted [RC];
    logic [31:0] v;
    unsorted = '{9, 3, 7, 1, 5, 8, 2, 6, 4, 10};
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
    rst = 1'b1;
    bus.d_mem_addr = 32'd0; bus.d_mem_wdata = 32'd0; bus.d_mem_wen = 4'h0;

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Sorted pass, done at cycle 20
    for (int i = 0; i < RC; i++) wr(RB + 32'(4 * i), 32'(i + 1), 4'hF, 1'b1);
    run_to_end(1'b1, 20, "t1");
    chk("t1_sum_const", res_sum, 32'd55);
    chk("t1_pass_const", {31'd0, pass}, 32'd1);

    // Unsorted region
    do_reset();
    for (int i = 0; i < RC; i++) wr(RB + 32'(4 * i), 32'(unsorted[i]), 4'hF, 1'b1);
    run_to_end(1'b1, cyc, "t2");
    chk("t2_inv_const", {16'd0, inv_count}, 32'd4);
    chk("t2_sum_const", res_sum, 32'd55);

    // Byte lanes
    do_reset();
    wr(RB, 32'h11223344, 4'hF, 1'b1);
    wr(RB, 32'hAABBCCDD, 4'b0001, 1'b1);
    rd_chk("t3_lane0", RB, 32'h112233DD);
    wr(RB, 32'hAABBCCDD, 4'b1100, 1'b1);
    rd_chk("t3_lane32", RB, 32'hAABB33DD);
    wr(RB, 32'hAABBCCDD, 4'b0000, 1'b1);
    rd_chk("t3_nolane", RB, 32'hAABB33DD);

    // Watchdog expiry with a sorted region, then done exactly on the last cycle
    do_reset();
    for (int i = 0; i < RC; i++) wr(RB + 32'(4 * i), 32'(i + 1), 4'hF, 1'b1);
    run_to_end(1'b0, 0, "t4a");
    chk("t4a_timeout_const", {31'd0, timeout}, 32'd1);
    chk("t4a_pass_const", {31'd0, pass}, 32'd0);
    do_reset();
    run_to_end(1'b1, MAXC - 1, "t4b");
    chk("t4b_timeout_const", {31'd0, timeout}, 32'd0);

    // Non-trigger, out-of-range and late writes
    do_reset();
    wr(DA, 32'd0, 4'hF, 1'b1);
    wr(DA, 32'hFFFFFF01, 4'b0001, 1'b1);
    tick(); tick();
    chk("t5_no_scan", {31'd0, scan_busy}, 32'd0);
    rd_chk("t5_partial_done", DA, 32'd1);
    wr(32'h1000, 32'd5, 4'hF, 1'b1);
    chk("t5_oob_flag", {31'd0, oob_write}, 32'd1);
    rd_chk("t5_oob_read", 32'h1000, 32'd0);
    run_to_end(1'b1, cyc, "t5");
    wr(RB, 32'd99, 4'hF, 1'b0);
    chk("t5_late_flag", {31'd0, late_write}, 32'd1);
    rd_chk("t5_late_mem", RB, model_mem[RB >> 2]);

    // Reset on the third scan cycle
    do_reset();
    wr(DA, 32'd1, 4'hF, 1'b1);
    tick(); tick();
    chk("t6_in_scan", {31'd0, scan_busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk_all_zero("t6_rst");
    rst = 1'b0;
    cyc = 0;
    tick();
    chk("t6_cycles_restart", cycles_run, 32'd1);
    rd_chk("t6_mem_kept", RB + 32'd4, model_mem[(RB >> 2) + 1]);

    // Randomized regions, lane writes and done timing
    for (int t = 0; t < 6; t++) begin
      do_reset();
      v = 32'd0;
      for (int i = 0; i < RC; i++) begin
        if (t % 2 == 1) v = v + $urandom_range(0, 3);
        else v = $urandom_range(0, 15);
        wr(RB + 32'(4 * i), v, 4'hF, 1'b1);
      end
      for (int j = 0; j < 3; j++) begin
        wr(RB + 32'(4 * $urandom_range(0, RC - 1)), $urandom, 4'($urandom_range(0, 15)), 1'b1);
      end
      if (t % 3 == 2) run_to_end(1'b0, 0, "rnd_to");
      else run_to_end(1'b1, $urandom_range(cyc, MAXC - 1), "rnd_done");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
